// File: rtl/code_display_scanner.sv
// Purpose : scans a stored 8-digit BCD passcode onto a time-multiplexed
//           7-segment display, with blanking of unentered digits and '-' masking.
// Latency : dig_sel/seg_out are registered, one cycle behind cur_digit/prescaler;
//           new codes take effect at the next frame wrap.
// Backpressure: none; a load that arrives before the wrap waits in pending
//           registers, and a later load overwrites the earlier one.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   enable              advance the scan; when low the scan holds and the display goes dark
//   load                one-cycle request to capture code_in/digit_cnt/mask_en
//   code_in             BCD digits, digit i = code_in[4i+3:4i]
//   digit_cnt           entered digit count (saturates at NUM_DIGITS)
//   mask_en             show entered digits as '-'
//   load_ack            one-cycle pulse when a captured code reaches the display
//   pending             a captured code is waiting for the frame boundary
//   cur_digit           slot currently being scanned
//   frame_done          one-cycle pulse after the last-to-first digit wrap
//   dig_sel             one-hot active-high digit enable
//   seg_out             segments {g,f,e,d,c,b,a}, active-high
module code_display_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 1024,
  parameter int BLANK      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [31:0]           code_in,
  input  logic [3:0]            digit_cnt,
  input  logic                  mask_en,
  output logic                  load_ack,
  output logic                  pending,
  output logic [2:0]            cur_digit,
  output logic                  frame_done,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [6:0]            seg_out
);

  localparam int              PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]      CNT_MAX    = 4'(NUM_DIGITS);
  localparam logic [6:0]      SEG_DASH   = 7'b1000000;

  // Scan timing state
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    cur_q, cur_d;
  logic          frame_done_q, frame_done_d;

  // Captured-but-not-yet-displayed code
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   pend_code_q, pend_code_d;
  logic [3:0]    pend_cnt_q, pend_cnt_d;
  logic          pend_mask_q, pend_mask_d;

  // Code currently on the display; only changes at a frame wrap
  logic [31:0]   sh_code_q, sh_code_d;
  logic [3:0]    sh_cnt_q, sh_cnt_d;
  logic          sh_mask_q, sh_mask_d;

  logic          ack_q, ack_d;

  // Registered display outputs
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;

  logic       tick;
  logic       wrap;
  logic [3:0] cnt_sat;
  logic [3:0] nib;
  logic       digit_entered;
  logic       in_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1111001;  // non-BCD nibble shows 'E'
    endcase
    return s;
  endfunction

  // Anti-ghosting window at the start of each slot; absent when BLANK is zero.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (presc_q < PW'(BLANK));
    end
  endgenerate

  assign tick          = enable && (presc_q == PRESC_LAST);
  assign wrap          = tick && (cur_q == DIGIT_LAST);
  assign cnt_sat       = (digit_cnt > CNT_MAX) ? CNT_MAX : digit_cnt;
  assign nib           = sh_code_q[{cur_q, 2'b00} +: 4];
  assign digit_entered = ({1'b0, cur_q} < sh_cnt_q);

  // Prescaler and digit counter
  always_comb begin
    presc_d      = presc_q;
    cur_d        = cur_q;
    frame_done_d = wrap;
    if (enable) begin
      if (tick) begin
        presc_d = '0;
        cur_d   = (cur_q == DIGIT_LAST) ? 3'd0 : cur_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Snapshot handshake: loads park in the pending registers and are moved to
  // the shadow only at a wrap. A load on the wrap edge itself is the newest
  // code, so it bypasses pending and goes straight to the shadow.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    pend_cnt_d  = pend_cnt_q;
    pend_mask_d = pend_mask_q;
    sh_code_d   = sh_code_q;
    sh_cnt_d    = sh_cnt_q;
    sh_mask_d   = sh_mask_q;
    ack_d       = 1'b0;
    if (wrap) begin
      if (load) begin
        sh_code_d = code_in;
        sh_cnt_d  = cnt_sat;
        sh_mask_d = mask_en;
        ack_d     = 1'b1;
      end else if (pend_vld_q) begin
        sh_code_d = pend_code_q;
        sh_cnt_d  = pend_cnt_q;
        sh_mask_d = pend_mask_q;
        ack_d     = 1'b1;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_code_d = code_in;
      pend_cnt_d  = cnt_sat;
      pend_mask_d = mask_en;
      pend_vld_d  = 1'b1;
    end
  end

  // Display decode, registered from the current scan position and shadow.
  always_comb begin
    sel_d = '0;
    seg_d = '0;
    if (enable) begin
      if (!digit_entered) begin
        seg_d = '0;
      end else if (sh_mask_q) begin
        seg_d = SEG_DASH;
      end else begin
        seg_d = bcd_to_seg(nib);
      end
      if (!in_blank) begin
        sel_d = NUM_DIGITS'(1) << cur_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      cur_q        <= '0;
      frame_done_q <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_code_q  <= '0;
      pend_cnt_q   <= '0;
      pend_mask_q  <= 1'b0;
      sh_code_q    <= '0;
      sh_cnt_q     <= '0;
      sh_mask_q    <= 1'b0;
      ack_q        <= 1'b0;
      sel_q        <= '0;
      seg_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      cur_q        <= cur_d;
      frame_done_q <= frame_done_d;
      pend_vld_q   <= pend_vld_d;
      pend_code_q  <= pend_code_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_mask_q  <= pend_mask_d;
      sh_code_q    <= sh_code_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_mask_q    <= sh_mask_d;
      ack_q        <= ack_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign load_ack   = ack_q;
  assign pending    = pend_vld_q;
  assign cur_digit  = cur_q;
  assign frame_done = frame_done_q;
  assign dig_sel    = sel_q;
  assign seg_out    = seg_q;

endmodule

// File: tb/tb_code_display_scanner.sv
// Purpose : self-checking bench for code_display_scanner (8 digits, 4-cycle slots, 1-cycle blank).
// Latency : expectations are queued per cycle and compared one cycle later after the clock edge.
// Backpressure: not applicable; the DUT never stalls its inputs.
module tb_code_display_scanner;

  localparam int N  = 8;
  localparam int P  = 4;
  localparam int BL = 1;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [31:0] code_in = '0;
  logic [3:0]  digit_cnt = '0;
  logic        mask_en = 1'b0;
  logic        load_ack;
  logic        pending;
  logic [2:0]  cur_digit;
  logic        frame_done;
  logic [N-1:0] dig_sel;
  logic [6:0]  seg_out;

  code_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .code_in(code_in), .digit_cnt(digit_cnt), .mask_en(mask_en),
    .load_ack(load_ack), .pending(pending), .cur_digit(cur_digit),
    .frame_done(frame_done), .dig_sel(dig_sel), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    logic [6:0]   seg;
    logic         fd;
    logic         ack;
    logic         pend;
    logic [2:0]   cur;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Reference model: scan position derived from the number of enabled cycles since reset.
  int          m_t = 0;
  logic [31:0] sh_code = '0;
  int          sh_cnt = 0;
  bit          sh_mask = 0;
  bit          pv = 0;
  logic [31:0] pd_code = '0;
  int          pd_cnt = 0;
  bit          pd_mask = 0;
  bit          prev_rn = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1111001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs at the falling edge and queue the
  // outputs the model predicts after the following rising edge.
  task automatic step(input bit en, input bit ld, input logic [31:0] code,
                      input logic [3:0] cnt, input bit msk, input bit rn);
    exp_t e;
    int p, d, scnt;
    bit wrap;
    @(negedge clk);
    enable = en; load = ld; code_in = code; digit_cnt = cnt; mask_en = msk; rst_n = rn;
    e = '{sel: '0, seg: '0, fd: 1'b0, ack: 1'b0, pend: 1'b0, cur: '0};
    if (!rn) begin
      m_t = 0; sh_code = '0; sh_cnt = 0; sh_mask = 0; pv = 0;
      if (prev_rn) begin
        #1;
        chk("reset_immediate", {20'd0, dig_sel, seg_out, pending, load_ack, frame_done},
            32'd0);
        chk("reset_immediate_cur", {29'd0, cur_digit}, 32'd0);
      end
    end else begin
      p = m_t % P;
      d = (m_t / P) % N;
      wrap = en && (p == P - 1) && (d == N - 1);
      scnt = (int'(cnt) > N) ? N : int'(cnt);
      if (en) begin
        if (d >= sh_cnt)   e.seg = 7'b0000000;
        else if (sh_mask)  e.seg = 7'b1000000;
        else               e.seg = seg_of(sh_code[4*d +: 4]);
        e.sel = (p >= BL) ? N'(1 << d) : '0;
      end
      e.fd  = wrap;
      e.ack = wrap && (ld || pv);
      if (wrap) begin
        if (ld) begin
          sh_code = code; sh_cnt = scnt; sh_mask = msk;
        end else if (pv) begin
          sh_code = pd_code; sh_cnt = pd_cnt; sh_mask = pd_mask;
        end
        pv = 0;
      end else if (ld) begin
        pd_code = code; pd_cnt = scnt; pd_mask = msk; pv = 1;
      end
      if (en) m_t++;
      e.cur  = 3'((m_t / P) % N);
      e.pend = pv;
    end
    prev_rn = rn;
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, 4'd0, 0, 1);
  endtask

  // Advance with scanning enabled until the model sits at the given frame phase.
  task automatic advance_to(input int phase);
    for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) step(1, 0, 32'h0, 4'd0, 0, 1);
  endtask

  // Monitor: every cycle the DUT presents a fresh set of registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("dig_sel",    {24'd0, dig_sel},    {24'd0, e.sel});
          chk("seg_out",    {25'd0, seg_out},    {25'd0, e.seg});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
          chk("load_ack",   {31'd0, load_ack},   {31'd0, e.ack});
          chk("pending",    {31'd0, pending},    {31'd0, e.pend});
          chk("cur_digit",  {29'd0, cur_digit},  {29'd0, e.cur});
        end
      end
    end
  end

  initial begin
    // Reset held, then released with scanning on and nothing loaded.
    step(0, 0, 32'h0, 4'd0, 0, 0);
    step(0, 0, 32'h0, 4'd0, 0, 0);
    idle(2 * FRAME + 6);

    // Full code, unmasked, loaded mid-frame.
    advance_to(10);
    step(1, 1, 32'h87654321, 4'd8, 0, 1);
    idle(2 * FRAME);

    // Three entered digits, masked.
    advance_to(7);
    step(1, 1, 32'h87654321, 4'd3, 1, 1);
    idle(2 * FRAME);

    // Two loads in one frame: the later one wins.
    advance_to(3);
    step(1, 1, 32'h00000001, 4'd1, 0, 1);
    idle(5);
    step(1, 1, 32'h00000009, 4'd1, 0, 1);
    idle(2 * FRAME);

    // Non-BCD nibble at digit 2, then an over-range count.
    advance_to(4);
    step(1, 1, 32'h76543A10, 4'd8, 0, 1);
    idle(2 * FRAME);
    advance_to(4);
    step(1, 1, 32'h76543A10, 4'd12, 0, 1);
    idle(2 * FRAME);

    // Load landing exactly on the wrap edge, with an older load still pending.
    advance_to(20);
    step(1, 1, 32'h11111111, 4'd8, 0, 1);
    advance_to(FRAME - 1);
    step(1, 1, 32'h22222222, 4'd5, 0, 1);
    idle(FRAME + 4);

    // Pause at digit 5, load while paused, then reset mid-frame.
    advance_to(5 * P + 1);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 4'd0, 0, 1);
    step(0, 1, 32'h55555555, 4'd8, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 4'd0, 0, 1);
    step(0, 0, 32'h0, 4'd0, 0, 0);
    step(0, 0, 32'h0, 4'd0, 0, 0);
    idle(FRAME + 4);

    // Randomized traffic including pauses, loads and occasional resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 199) != 0);
    end
    idle(4);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
